mem_arbiter_2p: RTL

Two-port arbiter and sequencer for the shared single-port main memory behind the two per-core direct-mapped caches of the dual-core MIPS. It accepts one word read or write from each cache controller over a req/ack handshake and grants in round-robin order. It drives the memory's altsyncram-style port and returns read data. Optionally, it broadcasts write invalidations to the other core's cache.

---
 rtl/mem_arbiter_2p.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p: round-robin req/ack arbiter and sequencer for one shared single-port memory.
// Optional feature macro ARB_SNOOP_INV_EN: a write by one port invalidates that line in the other cache.
`default_nettype none

module mem_arbiter_2p #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [11:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [11:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic        inv0_valid,
  output logic [7:0]  inv0_index,
  output logic        inv1_valid,
  output logic [7:0]  inv1_index,
  output logic [11:0] mem_address,
  output logic [31:0] mem_data,
  output logic        mem_rden,
  output logic        mem_wren,
  input  logic [31:0] mem_q,
  output logic        gnt_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int               CNT_W    = 3;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
    $error("mem_arbiter_2p: MEM_LAT must be in 1..7");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             last;
  logic             winner;
  logic             grant;
  logic             capture;
  logic             lat_we;
  logic [11:0]      lat_addr;
  logic [31:0]      lat_wdata;

  // On a tie the port that did not win last time is served.
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      winner = ~last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    mem_rden  = 1'b0;
    mem_wren  = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_rden  = ~lat_we;
        mem_wren  = lat_we;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_cnt == CNT_ONE) begin
          capture   = ~lat_we;
          state_nxt = DONE;
        end
      end
      DONE: begin
        ack0      = ~gnt_id;
        ack1      = gnt_id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction context is frozen at grant so late changes on the request side are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last      <= 1'b1;
      gnt_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 12'h000;
      lat_wdata <= 32'h0000_0000;
    end else if (grant) begin
      last      <= winner;
      gnt_id    <= winner;
      lat_we    <= winner ? we1 : we0;
      lat_addr  <= winner ? addr1 : addr0;
      lat_wdata <= winner ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= LAT_LOAD;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata0 <= 32'h0000_0000;
      rdata1 <= 32'h0000_0000;
    end else if (capture) begin
      if (gnt_id) begin
        rdata1 <= mem_q;
      end else begin
        rdata0 <= mem_q;
      end
    end
  end

  assign mem_address = lat_addr;
  assign mem_data    = lat_wdata;

`ifdef ARB_SNOOP_INV_EN
  // The invalidate rides with the writer's ack so the other cache drops its stale copy in step.
  assign inv0_valid = (state == DONE) && lat_we && gnt_id;
  assign inv1_valid = (state == DONE) && lat_we && !gnt_id;
  assign inv0_index = lat_addr[9:2];
  assign inv1_index = lat_addr[9:2];
`else
  assign inv0_valid = 1'b0;
  assign inv1_valid = 1'b0;
  assign inv0_index = 8'h00;
  assign inv1_index = 8'h00;
`endif

endmodule

`default_nettype wire
